spiral_routing_core: RTL and testbench

Single-clock, two-stage routing-decision pipeline for RPP packet headers. Parses a 144-bit header, looks up a Persistent Memory Anchor (PMA) record indexed by the header's window ID, and gates routing on coherence, consent and a sustained scalar-level trigger. It sits between the header parser front end and the forwarding fabric. Software or a control plane preloads the PMA table through a dedicated write port.

---
 rtl/spiral_routing_core.sv | 175 +++++++++++++++++
 tb/tb_spiral_routing_core.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spiral_routing_core.sv
// -----------------------------------------------------------------------------
// spiral_routing_core
//
// Two-stage routing-decision pipeline for RPP packet headers. Stage 1 registers
// the header, the request and the thresholds, and reads the PMA record selected
// by the header's window ID. Stage 2 turns those registers into a next-hop
// decision gated by consent, coherence and a sustained scalar-level trigger.
//
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   header_in/header_valid 144-bit header and its qualifier
//   dest_address           requested destination, sampled with the header
//   coherence_threshold    minimum coherence score for a direct route
//   scalar_threshold       scalar level that qualifies for the trigger
//   scalar_duration        consecutive qualifying headers needed to trigger
//   pma_write_*            PMA table preload port
//   resolved_address       chosen next hop
//   consent_state_out      consent state of the last header
//   coherence_score_out    coherence score of the last header
//   route_valid            routing decision valid (consent not suspended)
//   fallback_active        coherence too low, fallback address in use
//   scalar_triggered_out   sustained scalar condition met
//   pma_hit                PMA record matches the header window ID
// -----------------------------------------------------------------------------
module spiral_routing_core #(
    parameter int PMA_DEPTH = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [143:0] header_in,
    input  logic         header_valid,
    input  logic [31:0]  dest_address,
    input  logic [7:0]   coherence_threshold,
    input  logic [6:0]   scalar_threshold,
    input  logic [7:0]   scalar_duration,
    input  logic         pma_write_en,
    input  logic [5:0]   pma_write_addr,
    input  logic [143:0] pma_write_data,
    output logic [31:0]  resolved_address,
    output logic [1:0]   consent_state_out,
    output logic [7:0]   coherence_score_out,
    output logic         route_valid,
    output logic         fallback_active,
    output logic         scalar_triggered_out,
    output logic         pma_hit
);

    localparam int AW = $clog2(PMA_DEPTH);

    logic [143:0]         pma_mem [PMA_DEPTH];
    logic [PMA_DEPTH-1:0] pma_valid;

    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;
    logic          wr_ok;

    // Read index is the low window_id bits, i.e. window_id & (PMA_DEPTH-1).
    assign rd_idx = header_in[16 +: AW];
    assign wr_idx = pma_write_addr[AW-1:0];
    assign wr_ok  = pma_write_en && ({26'd0, pma_write_addr} < 32'(PMA_DEPTH));

    // NOTE: the record array has no reset; only the per-slot valid bits are
    // cleared, which is enough to make stale records invisible.
    always_ff @(posedge clk) begin
        if (rst_n && wr_ok)
            pma_mem[wr_idx] <= pma_write_data;
    end

    // Scalar counter next value (saturating at 255).
    logic [7:0] scalar_cnt;
    logic [7:0] scalar_cnt_next;

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        scalar_cnt_next = scalar_cnt;
        if (header_valid) begin
            if (header_in[38:32] >= scalar_threshold)
                scalar_cnt_next = (scalar_cnt == 8'hFF) ? scalar_cnt : scalar_cnt + 8'd1;
            else
                scalar_cnt_next = 8'd0;
        end
    end

    // Stage 1 registers
    logic         s1_valid;
    logic [31:0]  s1_origin;
    logic [7:0]   s1_coh;
    logic [1:0]   s1_consent;
    logic [11:0]  s1_wid;
    logic [31:0]  s1_dest;
    logic [7:0]   s1_coh_thr;
    logic [143:0] s1_rec;
    logic         s1_slot_valid;
    logic         s1_trig;

    // NOTE: sequential state uses non-blocking assignments; the valid bits are
    // read and written here on the same edge, so a same-slot write and header
    // see the old record and old valid bit (read-first).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pma_valid     <= '0;
            scalar_cnt    <= 8'd0;
            s1_valid      <= 1'b0;
            s1_origin     <= 32'd0;
            s1_coh        <= 8'd0;
            s1_consent    <= 2'd0;
            s1_wid        <= 12'd0;
            s1_dest       <= 32'd0;
            s1_coh_thr    <= 8'd0;
            s1_rec        <= 144'd0;
            s1_slot_valid <= 1'b0;
            s1_trig       <= 1'b0;
        end else begin
            if (wr_ok)
                pma_valid[wr_idx] <= 1'b1;
            s1_valid   <= header_valid;
            scalar_cnt <= scalar_cnt_next;
            if (header_valid) begin
                s1_origin     <= header_in[143:112];
                s1_coh        <= header_in[63:56];
                s1_consent    <= header_in[41:40];
                s1_wid        <= header_in[27:16];
                s1_dest       <= dest_address;
                s1_coh_thr    <= coherence_threshold;
                s1_rec        <= pma_mem[rd_idx];
                s1_slot_valid <= pma_valid[rd_idx];
                s1_trig       <= (scalar_cnt_next >= scalar_duration) && (scalar_cnt_next != 8'd0);
            end
        end
    end

    // Stage 2 decision
    logic s2_hit;
    logic s2_coh_ok;
    logic s2_route;
    logic s2_fallback;

    assign s2_hit      = s1_valid && s1_slot_valid && (s1_rec[143:132] == s1_wid);
    assign s2_coh_ok   = s1_coh >= s1_coh_thr;
    assign s2_route    = s1_valid && (s1_consent != 2'b11);
    assign s2_fallback = s2_route && !s2_coh_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resolved_address     <= 32'd0;
            consent_state_out    <= 2'd0;
            coherence_score_out  <= 8'd0;
            route_valid          <= 1'b0;
            fallback_active      <= 1'b0;
            scalar_triggered_out <= 1'b0;
            pma_hit              <= 1'b0;
        end else begin
            route_valid          <= s2_route;
            fallback_active      <= s2_fallback;
            pma_hit              <= s2_hit;
            scalar_triggered_out <= s1_trig;
            if (s1_valid) begin
                consent_state_out   <= s1_consent;
                coherence_score_out <= s1_coh;
                if (!s2_fallback)
                    resolved_address <= s1_dest;
                else if (s2_hit)
                    resolved_address <= s1_rec[31:0];
                else
                    resolved_address <= s1_origin;
            end
        end
    end

    // Header and record fields this block does not route on.
    logic unused_bits;
    assign unused_bits = ^{header_in, s1_rec, pma_write_addr};

endmodule

// File: tb/tb_spiral_routing_core.sv
module tb_spiral_routing_core;

    localparam int DEPTH = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [143:0] header_in;
    logic         header_valid;
    logic [31:0]  dest_address;
    logic [7:0]   coherence_threshold;
    logic [6:0]   scalar_threshold;
    logic [7:0]   scalar_duration;
    logic         pma_write_en;
    logic [5:0]   pma_write_addr;
    logic [143:0] pma_write_data;
    logic [31:0]  resolved_address;
    logic [1:0]   consent_state_out;
    logic [7:0]   coherence_score_out;
    logic         route_valid;
    logic         fallback_active;
    logic         scalar_triggered_out;
    logic         pma_hit;

    spiral_routing_core #(.PMA_DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .header_in            (header_in),
        .header_valid         (header_valid),
        .dest_address         (dest_address),
        .coherence_threshold  (coherence_threshold),
        .scalar_threshold     (scalar_threshold),
        .scalar_duration      (scalar_duration),
        .pma_write_en         (pma_write_en),
        .pma_write_addr       (pma_write_addr),
        .pma_write_data       (pma_write_data),
        .resolved_address     (resolved_address),
        .consent_state_out    (consent_state_out),
        .coherence_score_out  (coherence_score_out),
        .route_valid          (route_valid),
        .fallback_active      (fallback_active),
        .scalar_triggered_out (scalar_triggered_out),
        .pma_hit              (pma_hit)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  consent;
        logic [7:0]  coh;
        logic        route;
        logic        fb;
        logic        trig;
        logic        hit;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic hv_d1 = 1'b0;
    logic hv_d2 = 1'b0;

    localparam logic [31:0] ORG = 32'h42580000;
    localparam logic [31:0] DST = 32'h52680000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endtask

    function automatic logic [143:0] mk_hdr(input logic [7:0] coh, input logic [7:0] consent,
                                            input logic [7:0] scal, input logic [15:0] wid);
        return {ORG, 32'h00000001, 16'h0010, coh, 8'h2B, consent, scal, wid, 16'h0000};
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] addr, input logic [1:0] consent,
                                    input logic route, input logic fb, input logic trig,
                                    input logic hit);
        exp_t e;
        e.addr    = addr;
        e.consent = consent;
        e.coh     = 8'hF0;
        e.route   = route;
        e.fb      = fb;
        e.trig    = trig;
        e.hit     = hit;
        return e;
    endfunction

    // Output presentation tracker: a header accepted at edge N is presented
    // after edge N+1 unless a reset edge intervenes.
    always @(posedge clk) begin
        hv_d1 <= rst_n & header_valid;
        hv_d2 <= rst_n & hv_d1;
    end

    always @(negedge clk) begin
        if (hv_d2) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got route_valid=%0b, want no output", route_valid);
            end else begin
                mon_e = exp_q.pop_front();
                check("resolved_address", resolved_address, mon_e.addr);
                check("consent_state_out", 32'(consent_state_out), 32'(mon_e.consent));
                check("coherence_score_out", 32'(coherence_score_out), 32'(mon_e.coh));
                check("route_valid", 32'(route_valid), 32'(mon_e.route));
                check("fallback_active", 32'(fallback_active), 32'(mon_e.fb));
                check("scalar_triggered_out", 32'(scalar_triggered_out), 32'(mon_e.trig));
                check("pma_hit", 32'(pma_hit), 32'(mon_e.hit));
            end
        end
    end

    // Presents one header for one edge; pushes its expected outcome if it
    // is expected to reach the outputs.
    task automatic send(input logic [143:0] hdr, input logic [7:0] cthr, input logic [7:0] dur,
                        input exp_t e, input logic expect_out);
        header_in           = hdr;
        dest_address        = DST;
        coherence_threshold = cthr;
        scalar_threshold    = 7'd100;
        scalar_duration     = dur;
        header_valid        = 1'b1;
        if (expect_out)
            exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        header_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pma_write(input logic [5:0] addr, input logic [143:0] data);
        pma_write_en   = 1'b1;
        pma_write_addr = addr;
        pma_write_data = data;
        @(negedge clk);
        pma_write_en   = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_resolved_address"}, resolved_address, 32'd0);
        check({tag, "_consent_state_out"}, 32'(consent_state_out), 32'd0);
        check({tag, "_coherence_score_out"}, 32'(coherence_score_out), 32'd0);
        check({tag, "_route_valid"}, 32'(route_valid), 32'd0);
        check({tag, "_fallback_active"}, 32'(fallback_active), 32'd0);
        check({tag, "_scalar_triggered_out"}, 32'(scalar_triggered_out), 32'd0);
        check({tag, "_pma_hit"}, 32'(pma_hit), 32'd0);
    endtask

    initial begin
        rst_n               = 1'b0;
        header_in           = '0;
        header_valid        = 1'b0;
        dest_address        = '0;
        coherence_threshold = '0;
        scalar_threshold    = '0;
        scalar_duration     = '0;
        pma_write_en        = 1'b0;
        pma_write_addr      = '0;
        pma_write_data      = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_zero("reset");

        // Lookup before any write: slot invalid.
        send(mk_hdr(8'hF0, 8'h01, 8'h2A, 16'h0042), 8'd128, 8'd10, mk_exp(DST, 2'd1, 1, 0, 0, 0), 1);
        idle(2);

        // Preloaded slot: direct route with a hit.
        pma_write(6'd2, {12'h042, 132'hDEADBEEF});
        idle(3);
        send(mk_hdr(8'hF0, 8'h01, 8'h2A, 16'h0042), 8'd128, 8'd10, mk_exp(DST, 2'd1, 1, 0, 0, 1), 1);
        // Score equal to threshold still routes directly.
        send(mk_hdr(8'hF0, 8'h01, 8'h2A, 16'h0042), 8'hF0, 8'd10, mk_exp(DST, 2'd1, 1, 0, 0, 1), 1);
        idle(2);

        // Out-of-range slot write must not alias onto slot 2.
        pma_write(6'd34, {12'h042, 132'h11111111});
        idle(1);
        send(mk_hdr(8'hF0, 8'h01, 8'h2A, 16'h0042), 8'hF1, 8'd10, mk_exp(32'hDEADBEEF, 2'd1, 1, 1, 0, 1), 1);
        idle(2);

        // Mismatched stored window: fallback to origin.
        pma_write(6'd2, {12'h043, 132'hDEADBEEF});
        idle(1);
        send(mk_hdr(8'hF0, 8'h01, 8'h2A, 16'h0042), 8'hF1, 8'd10, mk_exp(ORG, 2'd1, 1, 1, 0, 0), 1);
        idle(2);

        // Suspended consent.
        send(mk_hdr(8'hF0, 8'h03, 8'h2A, 16'h0042), 8'd128, 8'd10, mk_exp(DST, 2'd3, 0, 0, 0, 0), 1);
        idle(2);

        // Sustained scalar level, duration 3; bit 7 of the scalar byte is ignored.
        send(mk_hdr(8'hF0, 8'h01, 8'h64, 16'h0042), 8'd128, 8'd3, mk_exp(DST, 2'd1, 1, 0, 0, 0), 1);
        send(mk_hdr(8'hF0, 8'h01, 8'hE4, 16'h0042), 8'd128, 8'd3, mk_exp(DST, 2'd1, 1, 0, 0, 0), 1);
        send(mk_hdr(8'hF0, 8'h01, 8'h64, 16'h0042), 8'd128, 8'd3, mk_exp(DST, 2'd1, 1, 0, 1, 0), 1);
        send(mk_hdr(8'hF0, 8'h01, 8'h10, 16'h0042), 8'hF1, 8'd3, mk_exp(ORG, 2'd1, 1, 1, 0, 0), 1);
        idle(2);
        // Bubble: flags drop, address holds.
        check("bubble_route_valid", 32'(route_valid), 32'd0);
        check("bubble_fallback_active", 32'(fallback_active), 32'd0);
        check("bubble_pma_hit", 32'(pma_hit), 32'd0);
        check("bubble_resolved_address", resolved_address, ORG);

        // Same-edge write and lookup of slot 2: old record, then new one.
        pma_write_en   = 1'b1;
        pma_write_addr = 6'd2;
        pma_write_data = {12'h042, 132'hCAFEF00D};
        send(mk_hdr(8'hF0, 8'h01, 8'h2A, 16'h0042), 8'hF1, 8'd10, mk_exp(ORG, 2'd1, 1, 1, 0, 0), 1);
        pma_write_en   = 1'b0;
        send(mk_hdr(8'hF0, 8'h01, 8'h2A, 16'h0042), 8'hF1, 8'd10, mk_exp(32'hCAFEF00D, 2'd1, 1, 1, 0, 1), 1);
        idle(2);

        // Mid-stream reset discards the in-flight header; a write during reset is dropped.
        send(mk_hdr(8'hF0, 8'h01, 8'h2A, 16'h0042), 8'hF1, 8'd10, mk_exp(ORG, 2'd1, 1, 1, 0, 0), 0);
        rst_n          = 1'b0;
        header_valid   = 1'b0;
        pma_write_en   = 1'b1;
        pma_write_addr = 6'd2;
        pma_write_data = {12'h042, 132'hBAD0BAD0};
        @(negedge clk);
        pma_write_en = 1'b0;
        rst_n        = 1'b1;
        check_zero("midreset");
        send(mk_hdr(8'hF0, 8'h01, 8'h2A, 16'h0042), 8'hF1, 8'd10, mk_exp(ORG, 2'd1, 1, 1, 0, 0), 1);
        idle(2);
        pma_write(6'd2, {12'h042, 132'hBEEF0001});
        idle(1);
        send(mk_hdr(8'hF0, 8'h01, 8'h2A, 16'h0042), 8'hF1, 8'd10, mk_exp(32'hBEEF0001, 2'd1, 1, 1, 0, 1), 1);
        idle(2);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++)
            @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d outstanding, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
